// File: rtl/hex_circle_scroller.sv
// hex_circle_scroller
//   Moves a single "circle" glyph across NUM_DIGITS seven-segment digits.
//   There are four modes: manual placement, scroll-left, scroll-right and
//   bounce. An internal divider fires one movement tick every TICK_DIV
//   cycles. Every output is registered.
//
// Ports
//   clk_i     system clock, rising edge
//   rst_ni    asynchronous active-low reset
//   enable_i  0 blanks the display and freezes all motion state
//   mode_i    00 manual, 01 scroll-left (+1), 10 scroll-right (-1), 11 bounce
//   pos_i     digit index used in manual mode
//   vert_i    1 = up circle (8'h63), 0 = down circle (8'h5C)
//   hex_o     digit d is hex_o[8*d +: 8]; an empty digit is 8'h00
//   pos_o     current position register
//   step_o    one-cycle pulse on each movement step
module hex_circle_scroller #(
    parameter int NUM_DIGITS = 6,
    parameter int TICK_DIV   = 50_000_000,
    parameter int POS_W      = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic [1:0]              mode_i,
    input  logic [POS_W-1:0]        pos_i,
    input  logic                    vert_i,
    output logic [8*NUM_DIGITS-1:0] hex_o,
    output logic [POS_W-1:0]        pos_o,
    output logic                    step_o
);

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_LEFT   = 2'b01;
    localparam logic [1:0] MODE_RIGHT  = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [7:0] SYM_UP   = 8'h63;
    localparam logic [7:0] SYM_DOWN = 8'h5C;

    localparam int              CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(NUM_DIGITS - 1);
    localparam logic [POS_W-1:0] POS_PENULT = POS_W'(NUM_DIGITS - 2);
    // One extra bit so the range check still works when NUM_DIGITS == 2**POS_W.
    localparam logic [POS_W:0]   POS_LIMIT  = (POS_W + 1)'(NUM_DIGITS);

    logic [CNT_W-1:0]        cnt_q,  cnt_d;
    logic [POS_W-1:0]        pos_q,  pos_d;
    logic                    dir_q,  dir_d;
    logic [1:0]              mode_q, mode_d;
    logic [8*NUM_DIGITS-1:0] hex_q,  hex_d;
    logic                    step_q, step_d;

    logic       mode_chg;
    logic       counting;
    logic       tick;
    logic       blank;
    logic       pos_q_valid;
    logic       pos_i_valid;
    logic       sym_sel;
    logic [7:0] sym;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        mode_chg    = (mode_i != mode_q);
        counting    = enable_i && (mode_i != MODE_MANUAL) && !mode_chg;
        tick        = counting && (cnt_q == CNT_LAST);
        pos_q_valid = ({1'b0, pos_q} < POS_LIMIT);
        pos_i_valid = ({1'b0, pos_i} < POS_LIMIT);

        cnt_d  = '0;
        pos_d  = pos_q;
        dir_d  = dir_q;
        blank  = !enable_i;
        step_d = tick;
        // mode_q tracks only while enabled, so a mode switched while blanked
        // still counts as a change (restarting the divider) on re-enable.
        mode_d = enable_i ? mode_i : mode_q;

        if (counting && !tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (enable_i) begin
            if (mode_chg && (mode_i == MODE_BOUNCE)) begin
                dir_d = DIR_UP;
            end

            if (mode_i == MODE_MANUAL) begin
                if (pos_i_valid) begin
                    pos_d = pos_i;
                end else begin
                    blank = 1'b1;
                end
            end else if (tick) begin
                if (!pos_q_valid) begin
                    pos_d = '0;
                end else begin
                    unique case (mode_i)
                        MODE_LEFT: begin
                            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
                        end
                        MODE_RIGHT: begin
                            pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
                        end
                        MODE_BOUNCE: begin
                            if (dir_q == DIR_UP) begin
                                if (pos_q == POS_LAST) begin
                                    dir_d = DIR_DOWN;
                                    pos_d = POS_PENULT;
                                end else begin
                                    pos_d = pos_q + POS_W'(1);
                                end
                            end else begin
                                if (pos_q == '0) begin
                                    dir_d = DIR_UP;
                                    pos_d = POS_W'(1);
                                end else begin
                                    pos_d = pos_q - POS_W'(1);
                                end
                            end
                        end
                        default: pos_d = pos_q;
                    endcase
                end
            end
        end

        // The glyph follows next-state direction so it flips on the same step
        // that reverses the bounce.
        sym_sel = vert_i ^ ((mode_i == MODE_BOUNCE) && (dir_d == DIR_DOWN));
        sym     = sym_sel ? SYM_UP : SYM_DOWN;

        // An out-of-range position matches no digit and so leaves all blank.
        hex_d = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (!blank && (pos_d == POS_W'(d))) begin
                hex_d[8*d +: 8] = sym;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample
    // their inputs together on the edge, regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            pos_q  <= '0;
            dir_q  <= DIR_UP;
            mode_q <= MODE_MANUAL;
            hex_q  <= '0;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            mode_q <= mode_d;
            hex_q  <= hex_d;
            step_q <= step_d;
        end
    end

    assign hex_o  = hex_q;
    assign pos_o  = pos_q;
    assign step_o = step_q;

endmodule

// File: tb/tb_hex_circle_scroller.sv
// tb_hex_circle_scroller
//   Directed bench for hex_circle_scroller with NUM_DIGITS = 6, TICK_DIV = 4.
//   It covers manual placement, both scroll directions with wrap, a full
//   bounce cycle with the glyph flip, a mode change that lands on a tick,
//   freezing while disabled, and asynchronous reset in the middle of a bounce.
module tb_hex_circle_scroller;

    localparam int NUM_DIGITS = 6;
    localparam int TICK_DIV   = 4;
    localparam int POS_W      = 3;

    logic                    clk;
    logic                    rst_n;
    logic                    enable;
    logic [1:0]              mode;
    logic [POS_W-1:0]        pos_in;
    logic                    vert;
    logic [8*NUM_DIGITS-1:0] hex;
    logic [POS_W-1:0]        pos;
    logic                    step;

    int n_tests = 0;
    int n_fail  = 0;

    hex_circle_scroller #(
        .NUM_DIGITS (NUM_DIGITS),
        .TICK_DIV   (TICK_DIV),
        .POS_W      (POS_W)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .enable_i (enable),
        .mode_i   (mode),
        .pos_i    (pos_in),
        .vert_i   (vert),
        .hex_o    (hex),
        .pos_o    (pos),
        .step_o   (step)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 ns past it before looking.
    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] hex_of(input int p, input logic [7:0] s);
        logic [47:0] r;
        r = '0;
        r[8*p +: 8] = s;
        return r;
    endfunction

    // Check all three outputs in one call.
    task automatic check_all(input string tag, input int exp_pos, input logic exp_step,
                             input logic [47:0] exp_hex);
        check({tag, ".pos"},  48'(pos),  48'(exp_pos));
        check({tag, ".step"}, 48'(step), 48'(exp_step));
        check({tag, ".hex"},  hex,       exp_hex);
    endtask

    // Three quiet cycles, then the tick edge with the expected landing state.
    task automatic expect_step(input string tag, input int exp_pos, input logic [7:0] exp_sym);
        repeat (3) tick_clk();
        check({tag, ".pre_step"}, 48'(step), 48'(0));
        tick_clk();
        check_all(tag, exp_pos, 1'b1, hex_of(exp_pos, exp_sym));
    endtask

    int          bpos [17] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 4, 3};
    logic [7:0]  bsym [17] = '{8'h5C, 8'h5C, 8'h5C, 8'h5C, 8'h5C,
                               8'h63, 8'h63, 8'h63, 8'h63, 8'h63,
                               8'h5C, 8'h5C, 8'h5C, 8'h5C, 8'h5C,
                               8'h63, 8'h63};
    int          lpos [4]  = '{5, 0, 1, 2};
    int          rpos [3]  = '{1, 0, 5};

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        mode   = 2'b00;
        pos_in = '0;
        vert   = 1'b0;

        // Reset state, both before and after a clock edge under reset.
        #3;
        check_all("reset", 0, 1'b0, 48'h0);
        tick_clk();
        check_all("reset_edge", 0, 1'b0, 48'h0);
        #2;
        rst_n = 1'b1;

        // 1. Manual placement and an out-of-range request.
        enable = 1'b1;
        mode   = 2'b00;
        pos_in = 3'd3;
        vert   = 1'b1;
        tick_clk();
        check_all("manual3", 3, 1'b0, 48'h0000_6300_0000);
        pos_in = 3'd7;
        tick_clk();
        check_all("manual7", 3, 1'b0, 48'h0);
        pos_in = 3'd4;
        tick_clk();
        check_all("manual4", 4, 1'b0, hex_of(4, 8'h63));

        // 2. Scroll-left from 4 wraps through 0; then scroll-right.
        mode = 2'b01;
        tick_clk();
        check_all("left_chg", 4, 1'b0, hex_of(4, 8'h63));
        for (int i = 0; i < 4; i++) expect_step($sformatf("left%0d", i), lpos[i], 8'h63);

        mode = 2'b10;
        tick_clk();
        check_all("right_chg", 2, 1'b0, hex_of(2, 8'h63));
        for (int i = 0; i < 3; i++) expect_step($sformatf("right%0d", i), rpos[i], 8'h63);

        // 4. A mode change that lands on the tick edge suppresses that step.
        mode = 2'b01;
        tick_clk();
        check_all("l2_chg", 5, 1'b0, hex_of(5, 8'h63));
        expect_step("l2_step", 0, 8'h63);
        repeat (3) tick_clk();
        mode = 2'b10;
        tick_clk();
        check_all("tick_chg", 0, 1'b0, hex_of(0, 8'h63));
        expect_step("after_chg", 5, 8'h63);

        // 5. Disable mid-scroll, then resume with a full divider period.
        repeat (2) tick_clk();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick_clk();
            check_all($sformatf("off%0d", i), 5, 1'b0, 48'h0);
        end
        enable = 1'b1;
        expect_step("resume", 4, 8'h63);

        // 3. Bounce from 0 with vert = 0; the return pass shows the other glyph.
        mode   = 2'b00;
        pos_in = 3'd0;
        tick_clk();
        check_all("home", 0, 1'b0, hex_of(0, 8'h63));
        vert = 1'b0;
        mode = 2'b11;
        tick_clk();
        check_all("bounce_chg", 0, 1'b0, hex_of(0, 8'h5C));
        for (int i = 0; i < 17; i++) expect_step($sformatf("bounce%0d", i), bpos[i], bsym[i]);

        // 6. Asynchronous reset while moving down at pos 3.
        tick_clk();
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 0, 1'b0, 48'h0);
        #2;
        rst_n = 1'b1;
        tick_clk();
        check_all("post_rst_chg", 0, 1'b0, hex_of(0, 8'h5C));
        expect_step("post_rst1", 1, 8'h5C);
        expect_step("post_rst2", 2, 8'h5C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
